// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEMORY stage of the five-stage MIPS pipeline. Performs word loads and
//   stores on a local data memory with a fixed multi-cycle latency, stalls
//   upstream while an access is in flight, resolves branch/jump redirection
//   and drives the MEM/WB pipeline register plus forwarding wires.
//
// Parameters
//   DEPTH_W     log2 of data memory depth in 32-bit words
//   MEM_LATENCY cycles a load/store occupies the stage (1..15)
//
// Ports
//   CLK, RST                          clock, asynchronous active-high reset
//   branch, jump, MemRead, MemWrite,
//   MemtoReg, RegWrite                control bits from EXECUTE
//   alu_out                           ALU result / byte address (bit 0 = branch cond)
//   readdata2                         store data
//   muxRegDst                         destination register
//   target                            branch/jump target
//   stall                             freezes upstream pipeline
//   pc_src, pc_target                 PC redirect request and target
//   addr_err                          pulse on misaligned memory op
//   MEMRegRd_wire, MEM_RegWrite_wire,
//   regExMem                          forwarding from stage inputs
//   wb_RegWrite, wb_MemtoReg,
//   wb_readdata, wb_aluout            MEM/WB register
//   WBRegRd_wire, WB_RegWrite_wire,
//   regMemWb                          forwarding from MEM/WB
module mem_access_stage #(
   parameter int DEPTH_W     = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        branch,
   input  logic        jump,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic [31:0] alu_out,
   input  logic [31:0] readdata2,
   input  logic [4:0]  muxRegDst,
   input  logic [31:0] target,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] pc_target,
   output logic        addr_err,
   output logic [4:0]  MEMRegRd_wire,
   output logic        MEM_RegWrite_wire,
   output logic [31:0] regExMem,
   output logic        wb_RegWrite,
   output logic        wb_MemtoReg,
   output logic [31:0] wb_readdata,
   output logic [31:0] wb_aluout,
   output logic [4:0]  WBRegRd_wire,
   output logic        WB_RegWrite_wire,
   output logic [31:0] regMemWb
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t             state;
   logic [3:0]         cnt;
   logic [4:0]         wb_regrd;
   logic [31:0]        mem [2**DEPTH_W];
   logic [DEPTH_W-1:0] idx;
   logic               mem_op;
   logic               commit;

   assign idx    = alu_out[DEPTH_W+1:2];
   assign mem_op = MemRead | MemWrite;
   assign commit = (state == WAIT) && (cnt == 4'd0);

   // Stall and addr_err are combinational so the stall is visible in the
   // same cycle the op is presented; both are forced low while reset is held.
   always_comb begin
      stall    = 1'b0;
      addr_err = 1'b0;
      if (!RST) begin
         if (state == IDLE) begin
            stall    = mem_op;
            addr_err = mem_op && (alu_out[1:0] != 2'b00);
         end else begin
            stall    = (cnt != 4'd0);
         end
      end
   end

   assign pc_src    = ~stall & ((branch & alu_out[0]) | jump);
   assign pc_target = target;

   assign MEMRegRd_wire     = muxRegDst;
   assign MEM_RegWrite_wire = RegWrite;
   assign regExMem          = alu_out;

   assign WBRegRd_wire     = wb_regrd;
   assign WB_RegWrite_wire = wb_RegWrite;
   assign regMemWb         = wb_MemtoReg ? wb_readdata : wb_aluout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         wb_RegWrite <= 1'b0;
         wb_MemtoReg <= 1'b0;
         wb_readdata <= '0;
         wb_aluout   <= '0;
         wb_regrd    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  state       <= WAIT;
                  cnt         <= 4'(MEM_LATENCY - 1);
                  wb_RegWrite <= 1'b0;
                  wb_MemtoReg <= 1'b0;
                  wb_readdata <= '0;
                  wb_aluout   <= '0;
                  wb_regrd    <= '0;
               end else begin
                  wb_RegWrite <= RegWrite;
                  wb_MemtoReg <= MemtoReg;
                  wb_readdata <= '0;
                  wb_aluout   <= alu_out;
                  wb_regrd    <= muxRegDst;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt         <= cnt - 4'd1;
                  wb_RegWrite <= 1'b0;
                  wb_MemtoReg <= 1'b0;
                  wb_readdata <= '0;
                  wb_aluout   <= '0;
                  wb_regrd    <= '0;
               end else begin
                  state       <= IDLE;
                  wb_RegWrite <= RegWrite;
                  wb_MemtoReg <= MemtoReg;
                  // Read+write together behaves as a store: no load data.
                  wb_readdata <= (MemRead && !MemWrite) ? mem[idx] : '0;
                  wb_aluout   <= alu_out;
                  wb_regrd    <= muxRegDst;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Reset forces state to IDLE asynchronously, so an in-flight store is
   // dropped without needing RST in this block.
   always_ff @(posedge CLK) begin
      if (commit && MemWrite)
         mem[idx] <= readdata2;
   end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   localparam int DW  = 8;
   localparam int LAT = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        branch, jump, MemRead, MemWrite, MemtoReg, RegWrite;
   logic [31:0] alu_out, readdata2, target;
   logic [4:0]  muxRegDst;
   logic        stall, pc_src, addr_err;
   logic [31:0] pc_target;
   logic [4:0]  MEMRegRd_wire;
   logic        MEM_RegWrite_wire;
   logic [31:0] regExMem;
   logic        wb_RegWrite, wb_MemtoReg;
   logic [31:0] wb_readdata, wb_aluout;
   logic [4:0]  WBRegRd_wire;
   logic        WB_RegWrite_wire;
   logic [31:0] regMemWb;

   int checks = 0;
   int errors = 0;

   // Reference memory: word index -> value, with a valid flag per word.
   logic [31:0] ref_mem [256];
   bit          ref_valid [256];

   mem_access_stage #(.DEPTH_W(DW), .MEM_LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .branch(branch), .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .alu_out(alu_out), .readdata2(readdata2), .muxRegDst(muxRegDst),
      .target(target),
      .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .addr_err(addr_err),
      .MEMRegRd_wire(MEMRegRd_wire), .MEM_RegWrite_wire(MEM_RegWrite_wire),
      .regExMem(regExMem),
      .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
      .wb_readdata(wb_readdata), .wb_aluout(wb_aluout),
      .WBRegRd_wire(WBRegRd_wire), .WB_RegWrite_wire(WB_RegWrite_wire),
      .regMemWb(regMemWb)
   );

   always #5 CLK = ~CLK;

   task automatic drive_nop();
      branch = 0; jump = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
      alu_out = '0; readdata2 = '0; muxRegDst = '0; target = '0;
   endtask

   // Presents one instruction, counts stall/addr_err cycles until the stage
   // completes, then returns #1 after the completing edge with nop driven.
   task automatic run_instr(input logic br, jp, mr, mw, mtr, rw,
                            input logic [31:0] ao, rd2, input logic [4:0] rd,
                            input logic [31:0] tg,
                            output int nstall, output int naerr,
                            output logic pc0, output logic [31:0] pt0,
                            output bit tmo);
      bit first = 1;
      bit done  = 0;
      branch = br; jump = jp; MemRead = mr; MemWrite = mw; MemtoReg = mtr;
      RegWrite = rw; alu_out = ao; readdata2 = rd2; muxRegDst = rd; target = tg;
      nstall = 0; naerr = 0; tmo = 0; pc0 = 0; pt0 = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (first) begin pc0 = pc_src; pt0 = pc_target; first = 0; end
         if (addr_err) naerr++;
         if (stall) nstall++;
         else begin done = 1; break; end
      end
      if (!done) tmo = 1;
      @(posedge CLK); #1;
      drive_nop();
   endtask

   task automatic test_reset();
      RST = 1; drive_nop();
      #12;
      // Load non-zero MEM/WB, then assert reset mid-cycle with a load presented.
      RST = 0;
      @(posedge CLK); #1;
      RegWrite = 1; MemtoReg = 0; alu_out = 32'h77; muxRegDst = 5'd9;
      @(posedge CLK); #1;
      MemRead = 1; alu_out = 32'h8;
      #2 RST = 1; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
      checks++; if ({wb_RegWrite, wb_MemtoReg, WB_RegWrite_wire} !== 3'b000) begin errors++; $display("FAIL reset_wbctl got %b want 000", {wb_RegWrite, wb_MemtoReg, WB_RegWrite_wire}); end
      checks++; if (wb_aluout !== 32'h0 || wb_readdata !== 32'h0 || WBRegRd_wire !== 5'd0) begin errors++; $display("FAIL reset_wbdata got %h/%h/%0d want 0", wb_aluout, wb_readdata, WBRegRd_wire); end
      checks++; if (regMemWb !== 32'h0) begin errors++; $display("FAIL reset_regMemWb got %h want 0", regMemWb); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
      drive_nop();
      @(posedge CLK); #2 RST = 0;
   endtask

   task automatic test_passthrough();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      RegWrite = 1; alu_out = 32'd3; muxRegDst = 5'd5; #1;
      checks++; if (MEMRegRd_wire !== 5'd5 || MEM_RegWrite_wire !== 1'b1 || regExMem !== 32'd3) begin errors++; $display("FAIL fwd_mem got %0d/%b/%h want 5/1/3", MEMRegRd_wire, MEM_RegWrite_wire, regExMem); end
      run_instr(0, 0, 0, 0, 0, 1, 32'd3, 32'h0, 5'd5, 32'h0, ns, na, p, pt, tmo);
      checks++; if (ns !== 0) begin errors++; $display("FAIL pass_stall got %0d want 0", ns); end
      checks++; if (wb_aluout !== 32'd3 || WBRegRd_wire !== 5'd5 || regMemWb !== 32'd3) begin errors++; $display("FAIL pass_wb got %h/%0d/%h want 3/5/3", wb_aluout, WBRegRd_wire, regMemWb); end
      checks++; if (WB_RegWrite_wire !== 1'b1 || wb_RegWrite !== 1'b1) begin errors++; $display("FAIL pass_regwrite got %b want 1", WB_RegWrite_wire); end
   endtask

   task automatic test_store_load();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      run_instr(0, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, ns, na, p, pt, tmo);
      ref_mem[4] = 32'hDEADBEEF; ref_valid[4] = 1;
      checks++; if (tmo || ns !== LAT) begin errors++; $display("FAIL store_stall got %0d want %0d", ns, LAT); end
      checks++; if (wb_RegWrite !== 1'b0 || wb_readdata !== 32'h0) begin errors++; $display("FAIL store_wb got %b/%h want 0/0", wb_RegWrite, wb_readdata); end
      run_instr(0, 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd8, 32'h0, ns, na, p, pt, tmo);
      checks++; if (tmo || ns !== LAT) begin errors++; $display("FAIL load_stall got %0d want %0d", ns, LAT); end
      checks++; if (regMemWb !== 32'hDEADBEEF || WBRegRd_wire !== 5'd8) begin errors++; $display("FAIL load_data got %h/%0d want deadbeef/8", regMemWb, WBRegRd_wire); end
      checks++; if (na !== 0) begin errors++; $display("FAIL load_addr_err got %0d want 0", na); end
   endtask

   task automatic test_back_to_back();
      int ns1, ns2, na; logic p; logic [31:0] pt; bit tmo;
      int t0, t1;
      t0 = int'($time);
      run_instr(0, 0, 0, 1, 0, 0, 32'h2C, 32'hCAFE0011, 5'd0, 32'h0, ns1, na, p, pt, tmo);
      run_instr(0, 0, 1, 0, 1, 1, 32'h2C, 32'h0, 5'd12, 32'h0, ns2, na, p, pt, tmo);
      t1 = int'($time);
      ref_mem[11] = 32'hCAFE0011; ref_valid[11] = 1;
      checks++; if (ns1 + ns2 !== 2 * LAT) begin errors++; $display("FAIL b2b_stall got %0d want %0d", ns1 + ns2, 2 * LAT); end
      checks++; if ((t1 - t0) !== 10 * 2 * (LAT + 1)) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", (t1 - t0) / 10, 2 * (LAT + 1)); end
      checks++; if (regMemWb !== 32'hCAFE0011) begin errors++; $display("FAIL b2b_data got %h want cafe0011", regMemWb); end
   endtask

   task automatic test_branch();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      run_instr(1, 0, 0, 0, 0, 0, 32'h1, 32'h0, 5'd0, 32'h40, ns, na, p, pt, tmo);
      checks++; if (p !== 1'b1 || pt !== 32'h40) begin errors++; $display("FAIL branch_taken got %b/%h want 1/40", p, pt); end
      run_instr(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h40, ns, na, p, pt, tmo);
      checks++; if (p !== 1'b0) begin errors++; $display("FAIL branch_not_taken got %b want 0", p); end
      run_instr(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h80, ns, na, p, pt, tmo);
      checks++; if (p !== 1'b1 || pt !== 32'h80) begin errors++; $display("FAIL jump got %b/%h want 1/80", p, pt); end
      run_instr(1, 1, 1, 0, 0, 0, 32'h11, 32'h0, 5'd0, 32'h80, ns, na, p, pt, tmo);
      checks++; if (p !== 1'b0) begin errors++; $display("FAIL branch_during_stall got %b want 0", p); end
   endtask

   task automatic test_misaligned_wrap();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      run_instr(0, 0, 1, 0, 1, 1, 32'h413, 32'h0, 5'd3, 32'h0, ns, na, p, pt, tmo);
      checks++; if (na !== 1) begin errors++; $display("FAIL misaligned_pulse got %0d want 1", na); end
      checks++; if (wb_readdata !== ref_mem[4] || wb_aluout !== 32'h413) begin errors++; $display("FAIL wrap_data got %h/%h want %h/413", wb_readdata, wb_aluout, ref_mem[4]); end
   endtask

   task automatic test_reset_mid_wait();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      run_instr(0, 0, 0, 1, 0, 0, 32'h20, 32'h55555555, 5'd0, 32'h0, ns, na, p, pt, tmo);
      ref_mem[8] = 32'h55555555; ref_valid[8] = 1;
      MemWrite = 1; alu_out = 32'h20; readdata2 = 32'h1234;
      @(negedge CLK);
      @(posedge CLK); #2;
      RST = 1; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midwait_stall got %b want 0", stall); end
      drive_nop();
      @(posedge CLK); #2 RST = 0;
      run_instr(0, 0, 1, 0, 1, 1, 32'h20, 32'h0, 5'd7, 32'h0, ns, na, p, pt, tmo);
      checks++; if (tmo || ns !== LAT) begin errors++; $display("FAIL midwait_relat got %0d want %0d", ns, LAT); end
      checks++; if (regMemWb !== 32'h55555555) begin errors++; $display("FAIL midwait_nocommit got %h want 55555555", regMemWb); end
   endtask

   task automatic test_random();
      int ns, na; logic p; logic [31:0] pt; bit tmo;
      for (int n = 0; n < 80; n++) begin
         int kind = int'($urandom_range(0, 3));
         int wi   = int'($urandom_range(0, 255));
         logic [31:0] ao, d, tg;
         logic [4:0]  rd;
         logic br, jp, mr, mw, mtr, rw;
         bit memop;
         int exp_ns, exp_na;
         logic exp_pc;
         logic [31:0] exp_rdata;
         if (kind == 2 && !ref_valid[wi]) kind = 1;
         br = 1'($urandom); jp = 1'($urandom); mtr = 1'($urandom); rw = 1'($urandom);
         d = $urandom; tg = $urandom; rd = 5'($urandom);
         ao = {22'($urandom), 8'(wi), 2'($urandom)};
         mr = (kind == 2) || (kind == 3);
         mw = (kind == 1) || (kind == 3);
         memop = mr || mw;
         exp_ns = memop ? LAT : 0;
         exp_na = (memop && ao[1:0] != 2'b00) ? 1 : 0;
         exp_pc = !memop && ((br && ao[0]) || jp);
         exp_rdata = (mr && !mw) ? ref_mem[wi] : 32'h0;
         run_instr(br, jp, mr, mw, mtr, rw, ao, d, rd, tg, ns, na, p, pt, tmo);
         if (mw) begin ref_mem[wi] = d; ref_valid[wi] = 1; end
         checks++; if (tmo || ns !== exp_ns) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", n, ns, exp_ns); end
         checks++; if (na !== exp_na) begin errors++; $display("FAIL rnd%0d_addr_err got %0d want %0d", n, na, exp_na); end
         checks++; if (p !== exp_pc || pt !== tg) begin errors++; $display("FAIL rnd%0d_pc got %b/%h want %b/%h", n, p, pt, exp_pc, tg); end
         checks++; if (wb_RegWrite !== rw || wb_MemtoReg !== mtr || WBRegRd_wire !== rd) begin errors++; $display("FAIL rnd%0d_wbctl got %b%b/%0d want %b%b/%0d", n, wb_RegWrite, wb_MemtoReg, WBRegRd_wire, rw, mtr, rd); end
         checks++; if (wb_aluout !== ao || wb_readdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_wbdata got %h/%h want %h/%h", n, wb_aluout, wb_readdata, ao, exp_rdata); end
         checks++; if (regMemWb !== (mtr ? exp_rdata : ao)) begin errors++; $display("FAIL rnd%0d_regMemWb got %h want %h", n, regMemWb, mtr ? exp_rdata : ao); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_valid[i] = 0; end
      test_reset();
      test_passthrough();
      test_store_load();
      test_back_to_back();
      test_branch();
      test_misaligned_wrap();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEMORY stage of the five-stage MIPS pipeline, directly downstream of EXECUTE. Consumes EXECUTE's registered outputs (ALU result, store data, destination register, control bits), performs word loads/stores on a local data memory with fixed multi-cycle latency, and stalls upstream while an access is in flight. It resolves branch/jump redirection and drives the MEM/WB pipeline register and the forwarding wires (MEMRegRd_wire, regExMem, WBRegRd_wire, regMemWb, ...) that EXECUTE consumes.

## Interface
- DEPTH_W, 8, log2 of data memory depth in 32-bit words (256 words)
- MEM_LATENCY, 2, cycles a load/store occupies the stage; legal range 1..15
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- branch, jump, MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from EXECUTE
- alu_out  in  32  ALU result or memory byte address; bit 0 = branch condition for BEQ/BNE
- readdata2  in  32  store data
- muxRegDst  in  5  destination register
- target  in  32  branch/jump target computed upstream
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  redirect PC to pc_target
- pc_target  out  32  equals target
- addr_err  out  1  one-cycle pulse: memory op with alu_out[1:0] != 0
- MEMRegRd_wire / MEM_RegWrite_wire / regExMem  out  5/1/32  forwarding: muxRegDst, RegWrite, alu_out passthrough
- wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control
- wb_readdata, wb_aluout  out  32 each  MEM/WB data
- WBRegRd_wire / WB_RegWrite_wire  out  5/1  copies of MEM/WB destination and RegWrite
- regMemWb  out  32  wb_MemtoReg ? wb_readdata : wb_aluout

## Operation
- Word index = alu_out[DEPTH_W+1:2]; higher bits ignored (address wraps), low two bits ignored for access.
- FSM states IDLE, WAIT; 4-bit down-counter cnt.
- IDLE, no memory op: stall=0; MEM/WB loads inputs at edge.
- IDLE, MemRead or MemWrite: stall=1, cnt<=MEM_LATENCY-1, ->WAIT; MEM/WB loads bubble (wb_RegWrite=0, wb_MemtoReg=0, data 0). addr_err pulses this cycle if misaligned.
- WAIT, cnt!=0: stall=1, cnt decrements, bubble into MEM/WB. Upstream holds inputs stable.
- WAIT, cnt==0: stall=0; store commits readdata2 to array at this edge; load captures array word into wb_readdata; MEM/WB loads control/aluout/RegRd; ->IDLE.
- MemRead and MemWrite both set: treated as store; wb_readdata=0.
- pc_src = ~stall & ((branch & alu_out[0]) | jump), combinational.
- Forwarding wires are combinational from stage inputs / MEM/WB register.
- Memory contents not affected by reset; uninitialised reads return X in sim.

## Timing
- Non-memory instruction: one cycle, result in MEM/WB after first edge.
- Memory op presented in cycle t: stall high cycles t..t+MEM_LATENCY-1, low in t+MEM_LATENCY; result in MEM/WB after edge ending cycle t+MEM_LATENCY; total stall cycles = MEM_LATENCY.
- Back-to-back memory ops: second starts in the cycle after the first completes (IDLE re-entered), no extra bubble.
- Store then load same address: load returns new data.
- Reset (any time, including mid-WAIT): immediately FSM=IDLE, cnt=0, stall=0, all MEM/WB outputs 0, addr_err=0; in-flight store is not committed.

## Test plan
- Reset: assert RST mid-cycle -> stall=0, wb_* =0, regMemWb=0 before next edge.
- ALU passthrough: RegWrite=1, alu_out=3, muxRegDst=5 -> next edge wb_aluout=3, WBRegRd_wire=5, regMemWb=3, stall never high.
- Store/load, MEM_LATENCY=2: store 0xDEADBEEF to alu_out=0x10 -> stall high exactly 2 cycles; then load 0x10 with MemtoReg=1, muxRegDst=8 -> after 2 stall cycles regMemWb=0xDEADBEEF, WBRegRd_wire=8.
- Branch: branch=1, alu_out=1, target=0x40 -> pc_src=1, pc_target=0x40; alu_out=0 -> pc_src=0; jump=1 -> pc_src=1.
- Misaligned/wrap: load alu_out=0x413 with DEPTH_W=8 -> addr_err one-cycle pulse, data from word index 4.
- Reset mid-WAIT of store 0x1234 to 0x20 -> later load of 0x20 returns prior contents, not 0x1234.
